// File: rtl/two_level_predictor_param.sv
// two_level_predictor_param: two-level adaptive branch predictor (PAg or gshare) with stats and sequenced PHT clear
module two_level_predictor_param #(
  parameter int PC_W      = 32,
  parameter int HIST_W    = 4,
  parameter int LHT_IDX_W = 4,
  parameter int CTR_W     = 2,
  parameter int MODE      = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_req,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pre_valid,
  output logic             pre_taken,
  input  logic             update_en,
  input  logic [PC_W-1:0]  update_pc,
  input  logic             real_br_taken,
  input  logic             update_pred,
  output logic             mispredict,
  input  logic             clear_req,
  output logic             busy,
  output logic [CNT_W-1:0] stat_pred_cnt,
  output logic [CNT_W-1:0] stat_misp_cnt
);
  localparam int PHT_N = 1 << HIST_W;
  localparam int LHT_N = 1 << LHT_IDX_W;
  localparam logic [CTR_W-1:0] WNT = {1'b0, {(CTR_W-1){1'b1}}};
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [CTR_W-1:0] pht [PHT_N];
  logic [HIST_W-1:0] lht [LHT_N];
  logic [HIST_W-1:0] ghr, ptr, p_idx, u_idx, u_hist;
  logic [LHT_IDX_W-1:0] p_li, u_li;
  logic [CTR_W-1:0] u_ctr, u_ctr_nx;
  logic misp, unused_bits;
  assign unused_bits = ^{pred_pc, update_pc};
  assign p_li = pred_pc[LHT_IDX_W+1:2];
  assign u_li = update_pc[LHT_IDX_W+1:2];
  assign p_idx = MODE == 0 ? lht[p_li] : pred_pc[HIST_W+1:2] ^ ghr;
  assign u_hist = MODE == 0 ? lht[u_li] : ghr;
  assign u_idx = MODE == 0 ? u_hist : update_pc[HIST_W+1:2] ^ ghr;
  assign u_ctr = pht[u_idx];
  assign u_ctr_nx = real_br_taken ? (&u_ctr ? u_ctr : u_ctr + CTR_W'(1))
                                  : (~|u_ctr ? u_ctr : u_ctr - CTR_W'(1));
  assign misp = update_pred ^ real_br_taken;
  assign busy = state == CLEAR;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (clear_req ? CLEAR : IDLE) : (&ptr ? IDLE : CLEAR);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= WNT;
      for (int i = 0; i < LHT_N; i++) lht[i] <= '0;
      ghr <= '0;
      ptr <= '0;
      pre_valid <= 1'b0;
      pre_taken <= 1'b0;
      mispredict <= 1'b0;
      stat_pred_cnt <= '0;
      stat_misp_cnt <= '0;
    end else begin
      pre_valid <= pred_req;
      if (pred_req) pre_taken <= (state == IDLE) & pht[p_idx][CTR_W-1];
      mispredict <= update_en & misp;
      if (update_en) begin
        stat_pred_cnt <= stat_pred_cnt + CNT_W'(stat_pred_cnt != '1);
        stat_misp_cnt <= stat_misp_cnt + CNT_W'(misp && stat_misp_cnt != '1);
      end
      if (state == CLEAR) begin
        pht[ptr] <= WNT;
        ptr <= ptr + HIST_W'(1);
      end else if (clear_req) begin
        for (int i = 0; i < LHT_N; i++) lht[i] <= '0;
        ghr <= '0;
        ptr <= '0;
      end else if (update_en) begin
        pht[u_idx] <= u_ctr_nx;
        if (MODE == 0) lht[u_li] <= (u_hist << 1) | HIST_W'(real_br_taken);
        else ghr <= (ghr << 1) | HIST_W'(real_br_taken);
      end
    end
  end
endmodule
